// File: rtl/mmio_sink.sv
// MMIO write sink: captures core MMIO writes into a FIFO drained over a valid/ready stream and
// halts once a write to StopAddr has been drained. Optional drop counter: MMIO_SINK_DROP_CNT_EN.
module mmio_sink #(
  parameter int unsigned              MMIOAddrWidth = 31,
  parameter int unsigned              DataWidth     = 64,
  parameter int unsigned              Depth         = 8,
  parameter logic [MMIOAddrWidth-1:0] StopAddr      = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     mmio_req_i,
  input  logic [MMIOAddrWidth-1:0] mmio_addr_i,
  input  logic [DataWidth-1:0]     mmio_wdata_i,
  input  logic [DataWidth/8-1:0]   mmio_strb_i,
  input  logic                     mmio_we_i,
  output logic [DataWidth-1:0]     mmio_rdata_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [MMIOAddrWidth-1:0] out_addr_o,
  output logic [DataWidth-1:0]     out_data_o,
  output logic [DataWidth/8-1:0]   out_strb_o,
  output logic                     halted_o,
  output logic                     overflow_o,
  output logic [31:0]              wr_cnt_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdxW      = $clog2(Depth);
  localparam int unsigned PtrW      = IdxW + 1;
  localparam int unsigned EntryW    = MMIOAddrWidth + DataWidth + StrbWidth;

  typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

  state_e                 state_q, state_d;
  logic                   halted_q, halted_d;
  logic                   overflow_q, overflow_d;
  logic [31:0]            wr_cnt_q, wr_cnt_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [PtrW-1:0]        wptr_q, wptr_d, rptr_q, rptr_d;
  logic [EntryW-1:0]      mem_q [Depth];
  logic [EntryW-1:0]      head;
  logic [63:0]            status;

  logic empty, full, offered, rd_req, pop, push, drop;

  // Extra pointer MSB tells a full FIFO from an empty one when the index bits match.
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]);
  assign offered = mmio_req_i && mmio_we_i;
  assign rd_req  = mmio_req_i && !mmio_we_i;
  assign pop     = !empty && out_ready_i;
  assign status  = {halted_q, overflow_q, 30'b0, wr_cnt_q};

  always_comb begin
    push       = 1'b0;
    drop       = 1'b0;
    state_d    = state_q;
    if (state_q == StRun && offered) begin
      // A pop in the same cycle frees the slot the write lands in.
      push = !full || pop;
      drop = full && !pop;
    end
    case (state_q)
      StRun:    if (offered && mmio_addr_i == StopAddr) state_d = StDrain;
      StDrain:  if (empty && !push) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
    halted_d   = (state_d == StHalted);
    wptr_d     = wptr_q + PtrW'(push);
    rptr_d     = rptr_q + PtrW'(pop);
    wr_cnt_d   = wr_cnt_q + 32'(push);
    overflow_d = overflow_q | drop;
    rdata_d    = rd_req ? DataWidth'(status) : rdata_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StRun;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      wr_cnt_q   <= '0;
      rdata_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      overflow_q <= overflow_d;
      wr_cnt_q   <= wr_cnt_d;
      rdata_q    <= rdata_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[IdxW-1:0]] <= {mmio_addr_i, mmio_wdata_i, mmio_strb_i};
  end

  assign head         = mem_q[rptr_q[IdxW-1:0]];
  assign out_valid_o  = !empty;
  assign out_addr_o   = head[EntryW-1 -: MMIOAddrWidth];
  assign out_data_o   = head[StrbWidth +: DataWidth];
  assign out_strb_o   = head[StrbWidth-1:0];
  assign halted_o     = halted_q;
  assign overflow_o   = overflow_q;
  assign wr_cnt_o     = wr_cnt_q;
  assign mmio_rdata_o = rdata_q;

`ifdef MMIO_SINK_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_cnt_q <= '0;
    else         drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt_o = drop_cnt_q;
`else
  assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mmio_sink.sv
// Self-checking bench for mmio_sink: directed scenarios plus random traffic against a
// queue-based reference model of the sink's write/drain/halt behaviour.
module tb_mmio_sink;

  localparam int Depth = 8;

  typedef struct packed {
    logic [30:0] a;
    logic [63:0] d;
    logic [7:0]  s;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        mmio_req_i = 1'b0;
  logic [30:0] mmio_addr_i = '0;
  logic [63:0] mmio_wdata_i = '0;
  logic [7:0]  mmio_strb_i = '0;
  logic        mmio_we_i = 1'b0;
  logic [63:0] mmio_rdata_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [30:0] out_addr_o;
  logic [63:0] out_data_o;
  logic [7:0]  out_strb_o;
  logic        halted_o;
  logic        overflow_o;
  logic [31:0] wr_cnt_o;
  logic [15:0] drop_cnt_o;

  mmio_sink #(
    .MMIOAddrWidth(31),
    .DataWidth    (64),
    .Depth        (Depth),
    .StopAddr     (31'h0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mmio_req_i  (mmio_req_i),
    .mmio_addr_i (mmio_addr_i),
    .mmio_wdata_i(mmio_wdata_i),
    .mmio_strb_i (mmio_strb_i),
    .mmio_we_i   (mmio_we_i),
    .mmio_rdata_o(mmio_rdata_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_addr_o  (out_addr_o),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .halted_o    (halted_o),
    .overflow_o  (overflow_o),
    .wr_cnt_o    (wr_cnt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: 0 = run, 1 = drain, 2 = halted.
  ent_t        q[$];
  int          m_phase;
  logic        m_ovf;
  logic [31:0] m_wr;
  int          m_drop;
  logic [63:0] m_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_drop();
`ifdef MMIO_SINK_DROP_CNT_EN
    return 16'(m_drop);
`else
    return 16'h0;
`endif
  endfunction

  task automatic model_cycle(input logic req, input logic we, input ent_t e, input logic rdy);
    int  sz  = q.size();
    bit  pop = (sz != 0) && rdy;
    bit  push = 0;
    bit  drp = 0;
    if (req && !we) m_rdata = {(m_phase == 2), m_ovf, 30'b0, m_wr};
    if (m_phase == 0 && req && we) begin
      if (sz < Depth || pop) push = 1;
      else                   drp  = 1;
    end
    if (m_phase == 0 && req && we && e.a == 31'h0) m_phase = 1;
    else if (m_phase == 1 && sz == 0)              m_phase = 2;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      m_wr = m_wr + 32'd1;
    end
    if (drp) begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  task automatic check_all();
    chk("valid", out_valid_o, q.size() != 0);
    if (q.size() != 0) begin
      chk("head_addr", out_addr_o, q[0].a);
      chk("head_data", out_data_o, q[0].d);
      chk("head_strb", out_strb_o, q[0].s);
    end
    chk("halted", halted_o, m_phase == 2);
    chk("overflow", overflow_o, m_ovf);
    chk("wr_cnt", wr_cnt_o, m_wr);
    chk("drop_cnt", drop_cnt_o, exp_drop());
    chk("rdata", mmio_rdata_o, m_rdata);
  endtask

  task automatic step(input logic req, input logic we, input ent_t e, input logic rdy);
    mmio_req_i   = req;
    mmio_we_i    = we;
    mmio_addr_i  = e.a;
    mmio_wdata_i = e.d;
    mmio_strb_i  = e.s;
    out_ready_i  = rdy;
    model_cycle(req, we, e, rdy);
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
  endtask

  task automatic do_reset();
    mmio_req_i  = 1'b0;
    mmio_we_i   = 1'b0;
    out_ready_i = 1'b0;
    rst_ni      = 1'b0;
    #1;
    chk("rst_valid", out_valid_o, 1'b0);
    chk("rst_halted", halted_o, 1'b0);
    chk("rst_overflow", overflow_o, 1'b0);
    chk("rst_wr_cnt", wr_cnt_o, 32'h0);
    chk("rst_drop_cnt", drop_cnt_o, 16'h0);
    chk("rst_rdata", mmio_rdata_o, 64'h0);
    q.delete();
    m_phase = 0;
    m_ovf   = 1'b0;
    m_wr    = '0;
    m_drop  = 0;
    m_rdata = '0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.a = 31'($urandom) | 31'h8;
    e.d = {$urandom, $urandom};
    e.s = 8'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [30:0] a, input logic [63:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    e.s = 8'hFF;
    return e;
  endfunction

  initial begin
    ent_t e;
    int   n;
    logic [30:0] last_addr;
    int   rdy_pct [4] = '{9, 5, 2, 7};

    #2;
    do_reset();

    // Three writes drained with ready held high.
    step(1, 1, mk(31'h100, 64'h1), 1);
    step(1, 1, mk(31'h108, 64'h2), 1);
    step(1, 1, mk(31'h110, 64'h3), 1);
    step(0, 0, mk(31'h8, 64'h0), 1);
    chk("s1_wr_cnt", wr_cnt_o, 32'd3);
    step(1, 0, mk(31'h8, 64'h0), 1);
    chk("s1_rdata", mmio_rdata_o, 64'h3);

    // Ten back-to-back writes with the stream stalled.
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, rnd_ent(), 0);
    chk("s2_overflow", overflow_o, 1'b1);
    chk("s2_wr_cnt", wr_cnt_o, 32'd8);
`ifdef MMIO_SINK_DROP_CNT_EN
    chk("s2_drop_cnt", drop_cnt_o, 16'd2);
`else
    chk("s2_drop_cnt", drop_cnt_o, 16'd0);
`endif

    // Full FIFO with simultaneous pop and write.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, rnd_ent(), 0);
    step(1, 1, rnd_ent(), 1);
    chk("s3_overflow", overflow_o, 1'b0);
    chk("s3_wr_cnt", wr_cnt_o, 32'd9);
    n = 0;
    while (out_valid_o && n < 20) begin
      step(0, 0, rnd_ent(), 1);
      n++;
    end
    chk("s3_occupancy", 64'(n), 64'd8);

    // Read after five pushes.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 1, rnd_ent(), 1'($urandom));
    step(1, 0, rnd_ent(), 0);
    chk("s4_rdata", mmio_rdata_o, 64'h5);

    // Stop write behind four pending entries, then two ignored writes.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, rnd_ent(), 0);
    step(1, 1, mk(31'h0, 64'h1), 0);
    step(1, 1, rnd_ent(), 0);
    step(1, 1, rnd_ent(), 0);
    chk("s5_wr_cnt", wr_cnt_o, 32'd5);
    n = 0;
    last_addr = '1;
    while (!halted_o && n < 40) begin
      if (out_valid_o) last_addr = out_addr_o;
      step(0, 0, rnd_ent(), 1);
      n++;
    end
    chk("s5_halt_reached", 64'(n < 40), 64'd1);
    chk("s5_stop_last", last_addr, 31'h0);
    step(1, 1, rnd_ent(), 1);
    chk("s5_wr_after_halt", wr_cnt_o, 32'd5);

    // Reset pulsed with three entries pending.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 1, rnd_ent(), 0);
    chk("s6_pending", out_valid_o, 1'b1);
    do_reset();
    step(0, 0, rnd_ent(), 1);

    // Random traffic with a varying drain rate; occasional stop writes.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int c = 0; c < 200; c++) begin
        e = rnd_ent();
        if ($urandom_range(0, 39) == 0) e.a = 31'h0;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, e,
             $urandom_range(0, 9) < rdy_pct[r]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
